// File: rtl/pc_seq_if.sv
// pc_seq_if -- bundle between the main control FSM and the program-counter unit.
//
// The control side (master) drives the write enables, the PC source select and
// the candidate targets. The sequencer (slave) returns the registered PC, its
// incremented value, the previous PC and its status outputs.
//
// Signals:
//   pc_we, pc_we_cond, zero   write enables and ALU zero flag
//   pc_src[1:0]               00 seq, 01 branch, 10 jump, 11 register
//   imm[OFF_W]                branch offset in instructions
//   jtarget[JT_W]             jump target field
//   rs_val[PC_W]              register jump target
//   stall, halt               freeze PC / enter HALT
//   pc, pc_plus, pc_prev      current, incremented and previous PC
//   pc_valid, misalign        RUN indicator, rejected-target pulse
//   upd_cnt[CNT_W]            accepted update counter
//   exc, epc                  exception request / saved PC (only with PC_EXC_EN)
interface pc_seq_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16,
    parameter int JT_W  = 26,
    parameter int CNT_W = 32
);
    logic             pc_we;
    logic             pc_we_cond;
    logic             zero;
    logic [1:0]       pc_src;
    logic [OFF_W-1:0] imm;
    logic [JT_W-1:0]  jtarget;
    logic [PC_W-1:0]  rs_val;
    logic             stall;
    logic             halt;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus;
    logic [PC_W-1:0]  pc_prev;
    logic             pc_valid;
    logic             misalign;
    logic [CNT_W-1:0] upd_cnt;
`ifdef PC_EXC_EN
    logic             exc;
    logic [PC_W-1:0]  epc;

    modport master (
        output pc_we, pc_we_cond, zero, pc_src, imm, jtarget, rs_val, stall, halt, exc,
        input  pc, pc_plus, pc_prev, pc_valid, misalign, upd_cnt, epc
    );
    modport slave (
        input  pc_we, pc_we_cond, zero, pc_src, imm, jtarget, rs_val, stall, halt, exc,
        output pc, pc_plus, pc_prev, pc_valid, misalign, upd_cnt, epc
    );
`else
    modport master (
        output pc_we, pc_we_cond, zero, pc_src, imm, jtarget, rs_val, stall, halt,
        input  pc, pc_plus, pc_prev, pc_valid, misalign, upd_cnt
    );
    modport slave (
        input  pc_we, pc_we_cond, zero, pc_src, imm, jtarget, rs_val, stall, halt,
        output pc, pc_plus, pc_prev, pc_valid, misalign, upd_cnt
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter unit for the multicycle MIPS datapath.
//
// Holds the PC register and selects the next PC (sequential, branch, jump or
// register). A BOOT/RUN/HALT FSM gates all writes; misaligned targets are
// rejected with a one-cycle misalign pulse; accepted updates are counted with
// a saturating counter.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_seq_if.slave (control inputs in, PC/status outputs out)
//
// Optional feature macro: PC_EXC_EN adds the exc input and the epc output.
// With it, exc in RUN loads EXC_VEC, saves the old PC in epc and pc_prev and
// counts as an update, taking precedence over halt, stall and normal writes.
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STEP     = 1,
    parameter int              OFF_W    = 16,
    parameter int              JT_W     = 26,
    parameter int              CNT_W    = 32,
    parameter logic [PC_W-1:0] EXC_VEC  = 'h20
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_seq_if.slave  bus
);
    localparam int SH = $clog2(STEP);
    // Low address bits that must be zero for an aligned target (empty for STEP=1).
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
    // Upper bits of pc_plus kept by a jump; zero when the field covers the whole PC.
    localparam logic [PC_W-1:0] JUMP_KEEP  = ~((PC_W'(1) << (JT_W + SH)) - PC_W'(1));

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_prev_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_sat;
    logic             misalign_reg;
    logic [PC_W-1:0]  pc_plus, imm_ext, target;
    logic             misaligned, wr, accept, exc_take;

`ifdef PC_EXC_EN
    logic [PC_W-1:0]  epc_reg;
    assign exc_take = (state_reg == RUN) & bus.exc;
    assign bus.epc  = epc_reg;
`else
    assign exc_take = 1'b0;
`endif

    // Next-PC datapath.
    always_comb begin
        pc_plus = pc_reg + PC_W'(STEP);
        imm_ext = {{(PC_W-OFF_W){bus.imm[OFF_W-1]}}, bus.imm};
        target  = pc_plus;
        case (bus.pc_src)
            2'b00: target = pc_plus;
            2'b01: target = pc_plus + (imm_ext << SH);
            2'b10: target = (pc_plus & JUMP_KEEP) | (PC_W'(bus.jtarget) << SH);
            2'b11: target = bus.rs_val;
            default: target = pc_plus;
        endcase
        misaligned = |(target & ALIGN_MASK);
        // halt and stall both block the write; an exception pre-empts it.
        wr = (state_reg == RUN) & ~bus.stall & ~bus.halt & ~exc_take
           & (bus.pc_we | (bus.pc_we_cond & bus.zero));
        accept  = wr & ~misaligned;
        cnt_sat = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    end

    // FSM next state: BOOT lasts one cycle; HALT is left only by reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     if (bus.halt && !exc_take) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            pc_prev_reg  <= RESET_PC;
            cnt_reg      <= '0;
            misalign_reg <= 1'b0;
`ifdef PC_EXC_EN
            epc_reg      <= '0;
`endif
        end else begin
            misalign_reg <= wr & misaligned;
            if (accept) begin
                pc_reg      <= target;
                pc_prev_reg <= pc_reg;
                cnt_reg     <= cnt_sat;
            end
`ifdef PC_EXC_EN
            if (exc_take) begin
                pc_reg      <= EXC_VEC;
                pc_prev_reg <= pc_reg;
                epc_reg     <= pc_reg;
                cnt_reg     <= cnt_sat;
            end
`endif
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.pc_plus  = pc_plus;
    assign bus.pc_prev  = pc_prev_reg;
    assign bus.pc_valid = (state_reg == RUN);
    assign bus.misalign = misalign_reg;
    assign bus.upd_cnt  = cnt_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- scoreboard bench for pc_sequencer.
// Two instances share the stimulus: dut0 with STEP=1 / CNT_W=32 and dut1 with
// STEP=4 / CNT_W=4 (alignment checks and counter saturation). Each stimulus
// cycle pushes the reference model's expected post-edge state; a monitor pops
// and compares one transaction per clock.
module tb_pc_sequencer;
    typedef longint unsigned u64;
    typedef struct {
        logic [31:0] pc, prev, cnt, plus, epc;
        logic        valid, mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        pc_we = 0, pc_we_cond = 0, zero = 0, stall = 0, halt = 0;
    logic [1:0]  pc_src = 0;
    logic [15:0] imm = 0;
    logic [25:0] jtarget = 0;
    logic [31:0] rs_val = 0;
`ifdef PC_EXC_EN
    logic        exc = 0;
`endif

    pc_seq_if #(.CNT_W(32)) bus0();
    pc_seq_if #(.CNT_W(4))  bus1();

    assign bus0.pc_we = pc_we;         assign bus1.pc_we = pc_we;
    assign bus0.pc_we_cond = pc_we_cond; assign bus1.pc_we_cond = pc_we_cond;
    assign bus0.zero = zero;           assign bus1.zero = zero;
    assign bus0.pc_src = pc_src;       assign bus1.pc_src = pc_src;
    assign bus0.imm = imm;             assign bus1.imm = imm;
    assign bus0.jtarget = jtarget;     assign bus1.jtarget = jtarget;
    assign bus0.rs_val = rs_val;       assign bus1.rs_val = rs_val;
    assign bus0.stall = stall;         assign bus1.stall = stall;
    assign bus0.halt = halt;           assign bus1.halt = halt;
`ifdef PC_EXC_EN
    assign bus0.exc = exc;             assign bus1.exc = exc;
`endif

    pc_sequencer #(.STEP(1), .CNT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pc_sequencer #(.STEP(4), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int total = 0;
    int bad = 0;

    // ---------------- reference model ----------------
    int unsigned step_of [2] = '{1, 4};
    logic [31:0] cnt_max [2] = '{32'hFFFF_FFFF, 32'd15};
    logic [31:0] m_pc[2], m_prev[2], m_cnt[2], m_epc[2];
    bit          m_booted[2], m_halted[2];
    exp_t        q0[$], q1[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_prev[i] = 0; m_cnt[i] = 0; m_epc[i] = 0;
            m_booted[i] = 0; m_halted[i] = 0;
        end
    endtask

    function automatic void bump(int i);
        if (m_cnt[i] != cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
    endfunction

    // Expected state after the next rising edge, given the current inputs.
    function automatic exp_t model_edge(int i);
        exp_t e;
        logic [31:0] plus, tgt;
        u64 blk;
        int off;
        bit mis = 0;
        plus = m_pc[i] + step_of[i];
        if (!m_booted[i]) begin
            m_booted[i] = 1;
        end else if (!m_halted[i]) begin
`ifdef PC_EXC_EN
            if (exc) begin
                m_prev[i] = m_pc[i]; m_epc[i] = m_pc[i]; m_pc[i] = 32'h20; bump(i);
            end else
`endif
            if (halt) begin
                m_halted[i] = 1;
            end else if (!stall && (pc_we || (pc_we_cond && zero))) begin
                case (pc_src)
                    2'd0: tgt = plus;
                    2'd1: begin
                        off = int'($signed(imm));
                        tgt = plus + 32'(off * int'(step_of[i]));
                    end
                    2'd2: begin
                        blk = u64'(67108864) * u64'(step_of[i]);   // 2^26 * STEP
                        tgt = 32'((u64'(plus) / blk) * blk + u64'(jtarget) * u64'(step_of[i]));
                    end
                    default: tgt = rs_val;
                endcase
                if (tgt % step_of[i] != 0) begin
                    mis = 1;
                end else begin
                    m_prev[i] = m_pc[i]; m_pc[i] = tgt; bump(i);
                end
            end
        end
        e.pc = m_pc[i]; e.prev = m_prev[i]; e.cnt = m_cnt[i]; e.epc = m_epc[i];
        e.plus = m_pc[i] + step_of[i];
        e.valid = m_booted[i] && !m_halted[i];
        e.mis = mis;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    function automatic exp_t snap(int i);
        exp_t a;
        if (i == 0) begin
            a.pc = bus0.pc; a.prev = bus0.pc_prev; a.cnt = bus0.upd_cnt; a.plus = bus0.pc_plus;
            a.valid = bus0.pc_valid; a.mis = bus0.misalign;
        end else begin
            a.pc = bus1.pc; a.prev = bus1.pc_prev; a.cnt = 32'(bus1.upd_cnt); a.plus = bus1.pc_plus;
            a.valid = bus1.pc_valid; a.mis = bus1.misalign;
        end
        a.epc = 0;
`ifdef PC_EXC_EN
        a.epc = (i == 0) ? bus0.epc : bus1.epc;
`endif
        return a;
    endfunction

    task automatic cmp_tx(int i, exp_t e, exp_t a);
        total++;
        if (a.pc !== e.pc || a.prev !== e.prev || a.cnt !== e.cnt || a.plus !== e.plus ||
            a.valid !== e.valid || a.mis !== e.mis || a.epc !== e.epc) begin
            bad++;
            $display("FAIL tx dut%0d: act pc=%h prev=%h cnt=%h plus=%h valid=%b mis=%b epc=%h | req pc=%h prev=%h cnt=%h plus=%h valid=%b mis=%b epc=%h",
                     i, a.pc, a.prev, a.cnt, a.plus, a.valid, a.mis, a.epc,
                     e.pc, e.prev, e.cnt, e.plus, e.valid, e.mis, e.epc);
        end else begin
            $display("tx dut%0d pc=%h prev=%h cnt=%0d valid=%b mis=%b", i, a.pc, a.prev, a.cnt, a.valid, a.mis);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) cmp_tx(0, q0.pop_front(), snap(0));
        if (q1.size() > 0) cmp_tx(1, q1.pop_front(), snap(1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic dchk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    task automatic drive(bit we, bit cond, bit z, logic [1:0] src, bit st, bit h);
        pc_we = we; pc_we_cond = cond; zero = z; pc_src = src; stall = st; halt = h;
    endtask

    // One clock: record the expectation, then let the edge happen.
    task automatic cycle();
        q0.push_back(model_edge(0));
        q1.push_back(model_edge(1));
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset: checked immediately, released on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        dchk("rst_pc0", bus0.pc, 32'h0);
        dchk("rst_pc1", bus1.pc, 32'h0);
        dchk("rst_cnt0", bus0.upd_cnt, 32'h0);
        dchk("rst_valid0", 32'(bus0.pc_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        dchk("boot_valid0", 32'(bus0.pc_valid), 32'h0);
    endtask

    initial begin
        #3;
        // Sequential stepping from reset.
        do_reset();
        drive(1, 0, 0, 2'b00, 0, 0);
        cycle();
        dchk("run_valid0", 32'(bus0.pc_valid), 32'h1);
        dchk("boot_pc0", bus0.pc, 32'h0);
        repeat (3) cycle();
        dchk("seq_pc0", bus0.pc, 32'd3);
        dchk("seq_cnt0", bus0.upd_cnt, 32'd3);
        dchk("seq_prev0", bus0.pc_prev, 32'd2);

        // Conditional branch, taken and not taken.
        rs_val = 32'd10; drive(1, 0, 0, 2'b11, 0, 0); cycle();
        imm = 16'hFFFD; drive(0, 1, 1, 2'b01, 0, 0); cycle();
        dchk("br_taken_pc0", bus0.pc, 32'd8);
        drive(1, 0, 0, 2'b11, 0, 0); cycle();
        drive(0, 1, 0, 2'b01, 0, 0); cycle();
        dchk("br_not_pc0", bus0.pc, 32'd10);
        dchk("br_not_cnt0", bus0.upd_cnt, 32'd6);

        // Jump keeps the upper PC bits; sequential wrap at all-ones.
        rs_val = 32'hF000_0004; drive(1, 0, 0, 2'b11, 0, 0); cycle();
        jtarget = 26'h000_0010; drive(1, 0, 0, 2'b10, 0, 0); cycle();
        dchk("jump_pc0", bus0.pc, 32'hF000_0010);
        rs_val = 32'hFFFF_FFFF; drive(1, 0, 0, 2'b11, 0, 0); cycle();
        drive(1, 0, 0, 2'b00, 0, 0); cycle();
        dchk("wrap_pc0", bus0.pc, 32'h0);

        // Misaligned register target on the STEP=4 instance.
        do_reset();
        rs_val = 32'h0000_0102; drive(1, 0, 0, 2'b11, 0, 0);
        cycle();
        cycle();
        dchk("mis_pulse1", 32'(bus1.misalign), 32'h1);
        dchk("mis_pc1", bus1.pc, 32'h0);
        dchk("mis_cnt1", 32'(bus1.upd_cnt), 32'h0);
        rs_val = 32'h0000_0100; cycle();
        dchk("mis_clear1", 32'(bus1.misalign), 32'h0);
        dchk("align_pc1", bus1.pc, 32'h100);

        // Stall holds, halt stops, later writes ignored, reset recovers.
        drive(1, 0, 0, 2'b00, 1, 0); cycle();
        dchk("stall_pc0", bus0.pc, 32'h100);
        drive(1, 0, 0, 2'b00, 1, 1); cycle();
        dchk("halt_valid0", 32'(bus0.pc_valid), 32'h0);
        drive(1, 0, 0, 2'b00, 0, 0); repeat (3) cycle();
        dchk("halt_pc0", bus0.pc, 32'h100);
        do_reset();

`ifdef PC_EXC_EN
        // Exception overrides stall.
        drive(0, 0, 0, 2'b00, 0, 0); cycle();
        rs_val = 32'd40; drive(1, 0, 0, 2'b11, 0, 0); cycle();
        exc = 1; drive(1, 0, 0, 2'b00, 1, 0); cycle();
        exc = 0;
        dchk("exc_pc0", bus0.pc, 32'h20);
        dchk("exc_epc0", bus0.epc, 32'd40);
        do_reset();
`endif

        // Randomized rounds.
        for (int r = 0; r < 3; r++) begin
            if (r > 0) do_reset();
            for (int n = 0; n < 100; n++) begin
                pc_we      = 1'($urandom_range(0, 1));
                pc_we_cond = 1'($urandom_range(0, 1));
                zero       = 1'($urandom_range(0, 1));
                pc_src     = 2'($urandom_range(0, 3));
                stall      = ($urandom_range(0, 3) == 0);
                halt       = ($urandom_range(0, 59) == 0);
                imm        = 16'($urandom);
                jtarget    = 26'($urandom);
                rs_val     = $urandom;
                if ($urandom_range(0, 1) == 1) rs_val = rs_val & 32'hFFFF_FFFC;
`ifdef PC_EXC_EN
                exc        = ($urandom_range(0, 19) == 0);
`endif
                cycle();
            end
        end
`ifdef PC_EXC_EN
        exc = 0;
`endif
        drive(0, 0, 0, 2'b00, 0, 0);
        @(posedge clk); #2;
        dchk("drained", 32'(q0.size() + q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
